// File: rtl/multdiv_seq.sv
// multdiv_seq -- iterative 32-bit signed multiply / divide unit.
//
// One add/subtract per cycle through a single 32-bit carry-lookahead adder,
// which is the only arithmetic datapath: it negates the multiplier or
// dividend at start, performs the shift-add / trial-subtract steps in RUN,
// and negates the magnitude result in FIX.
//
// Build option: define MULTDIV_DIV_EN to include the divider. Without it,
// a divide-only strobe completes one cycle later with data_exception = 1
// and data_result = 0; multiply is unaffected.
//
// Ports:
//   clock           in   single clock, rising edge
//   reset           in   synchronous, active-high
//   data_operandA   in   32  multiplicand / dividend (two's complement)
//   data_operandB   in   32  multiplier / divisor (two's complement)
//   ctrl_MULT       in   start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   start divide
//   data_result     out  32  low product word or quotient, held between results
//   data_exception  out  overflow / divide-by-zero / INT_MIN by -1
//   data_resultRDY  out  one-cycle pulse when result and exception are valid
//   busy            out  operation in flight
//
// state | meaning
// IDLE  | waiting for a start strobe
// RUN   | ITER shift-add (mult) or restoring-divide steps
// FIX   | sign correction and exception decision
// DONE  | result presented, data_resultRDY high

module multdiv_cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // 4-bit lookahead groups; group carries chain through a local variable
  always_comb begin
    logic carry;
    logic c0, c1, c2, c3, gg, gp;
    o_sum = '0;
    carry = i_cin;
    for (int k = 0; k < 8; k++) begin
      c0 = carry;
      c1 = w_g[4*k] | (w_p[4*k] & c0);
      c2 = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k]) | (w_p[4*k+1] & w_p[4*k] & c0);
      c3 = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
         | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
         | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c0);
      gg = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
         | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
         | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      gp = &w_p[4*k +: 4];
      o_sum[4*k +: 4] = w_p[4*k +: 4] ^ {c3, c2, c1, c0};
      carry = gg | (gp & c0);
    end
    o_cout = carry;
  end
endmodule

module multdiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  localparam int            CW      = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST    = CW'(ITER - 1);
  localparam logic [31:0]   INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  // mult: {carry, hi, lo}; div: {remainder[32:0], quotient[31:0]}
  logic [64:0]   r_acc;
  // raw multiplicand (mult) or raw divisor (div); its sign picks add vs subtract
  logic [31:0]   r_addend;
  logic          r_add_neg;
  logic          r_sign;
  logic [31:0]   r_result;
  logic          r_exc;
`ifdef MULTDIV_DIV_EN
  logic          r_is_mult;
  logic          r_div_exc;
`endif

  logic          w_start;
  logic [31:0]   w_neg_src;
  logic [31:0]   w_mag;
  logic [31:0]   w_add_a;
  logic [31:0]   w_add_b;
  logic          w_add_cin;
  logic [31:0]   w_add_sum;
  logic          w_add_cout;
  logic          w_sub;
  logic [64:0]   w_mul_pre;
  logic [64:0]   w_mul_nxt;
  logic          w_mul_exc;
  logic          w_exc;
  logic [64:0]   w_acc_nxt;
`ifdef MULTDIV_DIV_EN
  logic [64:0]   w_div_shift;
  logic          w_div_nonneg;
  logic [64:0]   w_div_nxt;
`endif

  assign w_start   = ctrl_MULT | ctrl_DIV;
  // multiplier magnitude goes into lo; dividend magnitude into the quotient half
  assign w_neg_src = ctrl_MULT ? data_operandB : data_operandA;
  assign w_mag     = w_neg_src[31] ? w_add_sum : w_neg_src;

`ifdef MULTDIV_DIV_EN
  // mult adds |A|: invert+1 when A is negative.
  // div subtracts |B|: invert+1 when B is positive, plain add of B when negative.
  assign w_sub = r_is_mult ? r_add_neg : ~r_add_neg;
`else
  assign w_sub = r_add_neg;
`endif

  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    if (w_start) begin
      w_add_a   = ~w_neg_src;
      w_add_cin = 1'b1;
    end else if (r_state == S_RUN) begin
`ifdef MULTDIV_DIV_EN
      w_add_a = r_is_mult ? r_acc[63:32] : w_div_shift[63:32];
`else
      w_add_a = r_acc[63:32];
`endif
      w_add_b   = w_sub ? ~r_addend : r_addend;
      w_add_cin = w_sub;
    end else if (r_state == S_FIX) begin
      w_add_a   = ~r_acc[31:0];
      w_add_cin = 1'b1;
    end
  end

  multdiv_cla32 u_cla (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  assign w_mul_pre = r_acc[0] ? {w_add_cout, w_add_sum, r_acc[31:0]} : r_acc;
  assign w_mul_nxt = {1'b0, w_mul_pre[64:1]};
  // magnitude limit is 0x7FFFFFFF for a positive result, 0x80000000 for negative
  assign w_mul_exc = (|r_acc[63:32]) |
                     (r_sign ? (r_acc[31] & (|r_acc[30:0])) : r_acc[31]);

`ifdef MULTDIV_DIV_EN
  assign w_div_shift  = {r_acc[63:0], 1'b0};
  // remainder stays below 2^32 after the shift, so the adder carry-out is the
  // "trial non-negative" flag; bit 32 is kept for completeness
  assign w_div_nonneg = w_div_shift[64] | w_add_cout;
  assign w_div_nxt    = w_div_nonneg ? {1'b0, w_add_sum, w_div_shift[31:1], 1'b1}
                                     : w_div_shift;
  assign w_acc_nxt    = r_is_mult ? w_mul_nxt : w_div_nxt;
  assign w_exc        = r_is_mult ? w_mul_exc : r_div_exc;
`else
  assign w_acc_nxt    = w_mul_nxt;
  assign w_exc        = w_mul_exc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_RUN:  if (r_cnt == LAST) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // a strobe restarts from any state, abandoning whatever was in flight
    if (w_start) begin
`ifdef MULTDIV_DIV_EN
      w_state_nxt = S_RUN;
`else
      w_state_nxt = ctrl_MULT ? S_RUN : S_DONE;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_addend  <= '0;
      r_add_neg <= 1'b0;
      r_sign    <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
`ifdef MULTDIV_DIV_EN
      r_is_mult <= 1'b0;
      r_div_exc <= 1'b0;
`endif
    end else if (w_start) begin
      r_cnt     <= '0;
      r_acc     <= {33'd0, w_mag};
      r_addend  <= ctrl_MULT ? data_operandA : data_operandB;
      r_add_neg <= ctrl_MULT ? data_operandA[31] : data_operandB[31];
      if (ctrl_MULT)
        r_sign <= (|data_operandA) & (|data_operandB) &
                  (data_operandA[31] ^ data_operandB[31]);
      else
        r_sign <= data_operandA[31] ^ data_operandB[31];
`ifdef MULTDIV_DIV_EN
      r_is_mult <= ctrl_MULT;
      r_div_exc <= (data_operandB == 32'd0) |
                   ((data_operandA == INT_MIN) & (&data_operandB));
`else
      if (!ctrl_MULT) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
        S_FIX: begin
          r_exc    <= w_exc;
          r_result <= w_exc  ? 32'd0 :
                      r_sign ? w_add_sum : r_acc[31:0];
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Iterative 32-bit signed multiply/divide unit in the execute stage, beside the ALU. It serves `mul`/`div` instructions and runs one add/subtract per cycle through a 32-bit carry-lookahead adder instance, which is its only arithmetic datapath. While `busy` is high, the pipeline stalls; it resumes when `data_resultRDY` pulses.

## Interface
- `ITER`, default 32: iteration count; equals the operand width and is fixed at 32.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `data_operandA`  in  32  multiplicand / dividend (two's complement).
- `data_operandB`  in  32  multiplier / divisor (two's complement).
- `ctrl_MULT`  in  1  start-multiply strobe, sampled each cycle.
- `ctrl_DIV`  in  1  start-divide strobe, sampled each cycle.
- `data_result`  out  32  low 32 bits of product, or quotient.
- `data_exception`  out  1  overflow (mult), divide-by-zero or INT_MIN/−1 (div).
- `data_resultRDY`  out  1  one-cycle pulse: result and exception valid.
- `busy`  out  1  operation in flight.

## Operation
- **Start.** A strobe seen in any state starts an operation. Operands and operation type are captured, and the state goes to RUN.
  - `ctrl_MULT` and `ctrl_DIV` high together: multiply wins.
  - Strobe while busy: the current operation is aborted silently (no RDY) and the new one restarts from setup.
- **States.**
  - IDLE, on a start strobe → RUN.
  - RUN, 32 iterations, iteration counter 0..31 → FIX.
  - FIX, one cycle → DONE.
  - DONE, one cycle → IDLE.
- **Setup.** Record the result sign:
  - multiply: A[31] xor B[31];
  - divide: quotient sign A[31] xor B[31].
  - Operands are converted to 32-bit magnitudes (negation through the adder, ~x + 1).
- **Multiply (RUN).** Unsigned shift-add over a 65-bit {carry, hi, lo} register:
  - lo holds the multiplier magnitude;
  - each cycle, if lo[0], hi ← hi + |A|;
  - then the whole register shifts right by 1.
- **Divide (RUN).** Restoring division over {remainder 33b, quotient 32b}:
  - each cycle, shift left;
  - trial subtract R − |B|;
  - if the trial is non-negative, keep it and set q[0] = 1; otherwise restore.
- **FIX.** Negate the result if the recorded sign is 1, then set the exception.
  - Multiply exception: 64-bit magnitude product > 0x7FFFFFFF for a positive sign, or > 0x80000000 for a negative sign.
  - Divide exception: B = 0, or A = 0x80000000 with B = 0xFFFFFFFF.
  - On any exception, `data_result` = 0.
  - Multiply with a zero operand: result 0, sign forced 0.
- **DONE.** Assert `data_resultRDY`.
- **Output hold.** `data_result` and `data_exception` hold their values from DONE until the next DONE or reset.

## Timing
- Cycle numbering: the strobe is high in cycle 0.
  - Cycles 1–32: RUN.
  - Cycle 33: FIX.
  - Cycle 34: `data_resultRDY` = 1, for that cycle only.
- Fixed latency of 34 cycles. There is no early termination.
- `busy` is 1 from cycle 1 through cycle 34 inclusive, and 0 in IDLE.
- A strobe in cycle 34 is accepted. Back-to-back throughput is one result per 34 cycles.
- Operands are sampled only in the strobe cycle; later changes to the inputs are ignored.
- Reset values: state IDLE, counter 0, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
- Reset asserted mid-operation: the next cycle is IDLE and no RDY is produced.
- Reset asserted together with a strobe: reset wins.

## Configuration
- Macro: `MULTDIV_DIV_EN`.
- Defined: full divide path as specified above.
- Undefined:
  - divider datapath and trial-subtract logic are omitted;
  - `ctrl_DIV` (without `ctrl_MULT`) goes directly to DONE;
  - `data_resultRDY` is high in cycle 1 with `data_result` = 0 and `data_exception` = 1;
  - multiply behaviour is unchanged.

## Test plan
- MULT, A = 7, B = −6 (0xFFFFFFFA) → cycle 34: result 0xFFFFFFD6, exception 0, RDY high for exactly one cycle, `busy` high in cycles 1–34.
- MULT, A = 0x00010000, B = 0x00010000 → result 0, exception 1. MULT, A = 0x80000000, B = 1 → result 0x80000000, exception 0.
- DIV, A = −43, B = 5 → result 0xFFFFFFF8 (−8), exception 0. DIV, A = 100, B = 0 → result 0, exception 1. DIV, A = 0x80000000, B = −1 → result 0, exception 1.
- MULT 3×4 started; DIV 20/3 strobed in cycle 10 → no RDY at cycle 34; single RDY at cycle 44 with result 6.
- MULT started; reset in cycle 15 → outputs zero, no RDY within 40 cycles. Strobe `ctrl_MULT` and `ctrl_DIV` together with A = 6, B = 3 → result 18.
- Build without `MULTDIV_DIV_EN`: DIV 20/3 → RDY in cycle 1, exception 1, result 0.
